// File: rtl/bcd_pkg.sv
// Shared constants for the BCD tick counter: digit width/limit and run-state encoding.
// Optional load path is enabled with BCD_TICK_COUNTER_LOAD_EN.
package bcd_pkg;

  localparam int         DIGIT_W   = 4;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  localparam logic STOPPED = 1'b0;
  localparam logic RUNNING = 1'b1;

  // Non-BCD nibbles saturate to 9 so the counter never holds an illegal digit.
  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_MAX) ? DIGIT_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit stepper: combinational next value and carry/borrow out.
// Chained per digit by bcd_tick_counter; carry means "this digit wrapped".
module bcd_digit
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               step,
  input  logic               up,
  output logic [DIGIT_W-1:0] next,
  output logic               carry
);

  always_comb begin
    next  = digit;
    carry = 1'b0;
    if (step) begin
      if (up) begin
        if (digit == DIGIT_MAX) begin
          next  = '0;
          carry = 1'b1;
        end else begin
          next = digit + 4'd1;
        end
      end else begin
        if (digit == '0) begin
          next  = DIGIT_MAX;
          carry = 1'b1;
        end else begin
          next = digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD up/down counter advanced by rising edges of a selected slow enable.
// Define BCD_TICK_COUNTER_LOAD_EN to add the load/load_val parallel-load path.
//
// state   | meaning
// STOPPED | ticks are discarded
// RUNNING | each tick steps the count by one
module bcd_tick_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  slw_clk_1,
  input  logic                  slw_clk_2,
  input  logic                  speed_sel,
  input  logic                  start_stop,
  input  logic                  clear,
  input  logic                  up_dn,
`ifdef BCD_TICK_COUNTER_LOAD_EN
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
`endif
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  wrap
);

  logic                state;
  logic                prev_1;
  logic                prev_2;
  logic                tick;
  logic [DIGITS:0]     step;
  logic [4*DIGITS-1:0] next_count;

  // prev_* track both inputs every cycle so a speed switch cannot fake an edge.
  assign tick    = speed_sel ? (slw_clk_2 & ~prev_2) : (slw_clk_1 & ~prev_1);
  assign step[0] = tick & (state == RUNNING);
  assign running = state;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .digit (count[g*DIGIT_W +: DIGIT_W]),
      .step  (step[g]),
      .up    (up_dn),
      .next  (next_count[g*DIGIT_W +: DIGIT_W]),
      .carry (step[g+1])
    );
  end

`ifdef BCD_TICK_COUNTER_LOAD_EN
  logic [4*DIGITS-1:0] load_clamped;

  for (genvar g = 0; g < DIGITS; g++) begin : g_clamp
    assign load_clamped[g*DIGIT_W +: DIGIT_W] = clamp_digit(load_val[g*DIGIT_W +: DIGIT_W]);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= '0;
      wrap   <= 1'b0;
      state  <= STOPPED;
      prev_1 <= slw_clk_1;
      prev_2 <= slw_clk_2;
    end else begin
      prev_1 <= slw_clk_1;
      prev_2 <= slw_clk_2;
      if (start_stop) state <= ~state;
      if (clear) begin
        count <= '0;
        wrap  <= 1'b0;
`ifdef BCD_TICK_COUNTER_LOAD_EN
      end else if (load) begin
        count <= load_clamped;
        wrap  <= 1'b0;
`endif
      end else begin
        // A carry out of the top digit is the roll-over / roll-under event.
        count <= next_count;
        wrap  <= step[DIGITS];
      end
    end
  end

endmodule
